// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM access arbiter: access FSM states and grant encoding.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    WR_HOLD = 2'd2,
    RD      = 2'd3
  } sram_arb_state_e;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } sram_gnt_e;

endpackage

// File: rtl/sram_rr_picker.sv
// Two-way round-robin picker between the recorder (write) and player (read) requesters.
module sram_rr_picker
  import sram_arb_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_wr_req,
  input  logic      i_rd_req,
  input  logic      i_grant_en,
  output sram_gnt_e o_gnt,
  output logic      o_gnt_valid
);

  sram_gnt_e last_grant_q, last_grant_d;

  // A tie goes to whichever side was not served last; starting from RD makes the first tie a write.
  always_comb begin
    o_gnt = GNT_RD;
    if (i_wr_req && i_rd_req) begin
      o_gnt = (last_grant_q == GNT_RD) ? GNT_WR : GNT_RD;
    end else if (i_wr_req) begin
      o_gnt = GNT_WR;
    end
    o_gnt_valid  = i_grant_en && (i_wr_req || i_rd_req);
    last_grant_d = o_gnt_valid ? o_gnt : last_grant_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant_q <= GNT_RD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Owns the async SRAM pins and sequences write/read accesses from two requesters
// through an address-setup / strobe / hold / turnaround FSM.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  localparam int               CNT_W      = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  sram_arb_state_e   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ack_q, wr_ack_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              ce_n_q, ce_n_d;
  logic              dq_oe_q, dq_oe_d;

  sram_gnt_e gnt;
  logic      gnt_valid;
  logic      last_strobe;

  sram_rr_picker u_picker (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wr_req    (i_wr_req),
    .i_rd_req    (i_rd_req),
    .i_grant_en  (state_q == IDLE),
    .o_gnt       (gnt),
    .o_gnt_valid (gnt_valid)
  );

  assign last_strobe = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          cnt_d = CNT_RELOAD;
          if (gnt == GNT_WR) begin
            state_d = WR;
            addr_d  = i_wr_addr;
            wdata_d = i_wr_data;
          end else begin
            state_d = RD;
            addr_d  = i_rd_addr;
          end
        end
      end
      WR: begin
        if (last_strobe) state_d = WR_HOLD;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      WR_HOLD: state_d = IDLE;
      RD: begin
        if (last_strobe) begin
          state_d    = IDLE;
          rd_data_d  = io_SRAM_DQ;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin controls are registered from the next state so strobes never glitch on a state decode.
    wr_ack_d = (state_d == WR_HOLD);
    we_n_d   = (state_d != WR);
    oe_n_d   = (state_d != RD);
    ce_n_d   = (state_d == IDLE);
    dq_oe_d  = (state_d == WR) || (state_d == WR_HOLD);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      ce_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      ce_n_q     <= ce_n_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  assign io_SRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;
  assign o_wr_ack    = wr_ack_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench: async SRAM model plus a transaction-level reference for grant order, latency and data.
module tb_sram_access_arbiter;

  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_req = 1'b0;
  logic [19:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic [19:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n;

  int n_asserts = 0;
  int n_fail    = 0;

  sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(AC)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_req    (wr_req),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_wr_ack    (wr_ack),
    .i_rd_req    (rd_req),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .o_busy      (busy),
    .o_SRAM_ADDR (sram_addr),
    .io_SRAM_DQ  (sram_dq),
    .o_SRAM_WE_N (sram_we_n),
    .o_SRAM_OE_N (sram_oe_n),
    .o_SRAM_CE_N (sram_ce_n),
    .o_SRAM_LB_N (sram_lb_n),
    .o_SRAM_UB_N (sram_ub_n)
  );

  initial forever #5 clk = ~clk;

  // Released bus floats high, so an undriven DQ reads as all ones.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pull
    pullup (sram_dq[gi]);
  end

  // Async SRAM: drives while selected with OE low, latches data on the WE_N rising edge.
  logic [15:0] mem [0:(1<<20)-1];
  assign sram_dq = (!sram_oe_n && !sram_ce_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;
  always @(posedge sram_we_n) if (sram_ce_n === 1'b0) mem[sram_addr] = sram_dq;

  // Reference model state
  logic [15:0] ref_mem [logic [19:0]];
  logic [19:0] pool[$];
  bit          model_last_rd = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sram_ce_n === 1'b1) check("dq_released", {16'h0, sram_dq}, 32'h0000FFFF);
    if (sram_oe_n === 1'b0) begin
      check("no_oe_we_overlap", {31'h0, sram_we_n}, 32'h1);
      check("no_dq_contention", {16'h0, sram_dq}, {16'h0, mem[sram_addr]});
    end
  endtask

  task automatic do_reset();
    wr_req = 1'b0;
    rd_req = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last_rd = 1'b1;
  endtask

  // One write and/or read raised together while idle; order, latency and data from the grant rules.
  task automatic run_txn(input bit do_wr, input bit do_rd, input logic [19:0] wa,
                         input logic [15:0] wd, input logic [19:0] ra);
    bit          wr_first;
    int          exp_wr_t, exp_rd_t, wr_t, rd_t, n_ack, n_val;
    logic [15:0] exp_rd, got_rd;
    wr_t = -1; rd_t = -1; n_ack = 0; n_val = 0; exp_rd = '0; got_rd = '0;
    check("idle_before_txn", {31'h0, busy}, 32'h0);
    wr_first = (do_wr && do_rd) ? model_last_rd : do_wr;
    if (do_wr && do_rd) begin
      exp_wr_t = wr_first ? AC + 1 : 2 * AC + 2;
      exp_rd_t = wr_first ? 2 * AC + 3 : AC + 1;
    end else begin
      exp_wr_t = AC + 1;
      exp_rd_t = AC + 1;
    end
    if (do_rd) exp_rd = (do_wr && wr_first && wa == ra) ? wd : ref_mem[ra];
    if (do_wr) begin
      if (!ref_mem.exists(wa)) pool.push_back(wa);
      ref_mem[wa] = wd;
    end
    if (do_wr && do_rd) model_last_rd = wr_first;
    else                model_last_rd = do_rd;

    wr_addr = wa; wr_data = wd; wr_req = do_wr;
    rd_addr = ra; rd_req = do_rd;
    for (int t = 1; t <= 2 * AC + 8; t++) begin
      tick();
      if (wr_ack) begin n_ack++; wr_t = t; wr_req = 1'b0; end
      if (rd_valid) begin n_val++; rd_t = t; got_rd = rd_data; rd_req = 1'b0; end
    end
    $display("txn wr=%0b rd=%0b waddr=%05h wdata=%04h raddr=%05h ack@%0d valid@%0d rdata=%04h",
             do_wr, do_rd, wa, wd, ra, wr_t, rd_t, got_rd);
    check("wr_ack_count", n_ack, {31'h0, do_wr});
    check("rd_valid_count", n_val, {31'h0, do_rd});
    if (do_wr) check("wr_ack_latency", wr_t, exp_wr_t);
    if (do_rd) begin
      check("rd_valid_latency", rd_t, exp_rd_t);
      check("rd_data", {16'h0, got_rd}, {16'h0, exp_rd});
    end
  endtask

  initial begin
    int          ev[$];
    int          n_ev, n_oe, n_ack, n_val, val_t;
    logic [15:0] abort_pre;

    // Reset values, then a long quiet stretch
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {28'h0, sram_we_n, sram_oe_n, sram_ce_n, busy}, 32'hE);
    check("rst_addr", {12'h0, sram_addr}, 32'h0);
    check("rst_dq", {16'h0, sram_dq}, 32'h0000FFFF);
    check("rst_rd_data", {16'h0, rd_data}, 32'h0);
    check("rst_ack_valid", {30'h0, wr_ack, rd_valid}, 32'h0);
    check("rst_lb_ub", {30'h0, sram_lb_n, sram_ub_n}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_quiet", {27'h0, sram_we_n, sram_oe_n, sram_ce_n, busy, wr_ack | rd_valid}, 32'h1C);
    end

    // Write then read back
    run_txn(1'b1, 1'b0, 20'h00010, 16'hBEEF, 20'h0);
    run_txn(1'b0, 1'b1, 20'h0, 16'h0, 20'h00010);

    // Both requests held: strict alternation starting with the write
    do_reset();
    if (!ref_mem.exists(20'h00200)) pool.push_back(20'h00200);
    ref_mem[20'h00200] = 16'h7777;
    wr_addr = 20'h00200; wr_data = 16'h7777; rd_addr = 20'h00200;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int t = 0; t < 80 && ev.size() < 6; t++) begin
      tick();
      if (wr_ack) ev.push_back(0);
      if (rd_valid) begin
        ev.push_back(1);
        check("rr_rd_data", {16'h0, rd_data}, 32'h7777);
      end
      if (ev.size() >= 6) begin wr_req = 1'b0; rd_req = 1'b0; end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("rr_grant_count", ev.size(), 6);
    for (int i = 0; i < ev.size() && i < 6; i++) begin
      $display("rr grant %0d: %s", i, ev[i] == 0 ? "WR" : "RD");
      check("rr_order", ev[i], i % 2);
    end
    n_ev = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (wr_ack || rd_valid) n_ev++;
    end
    check("rr_no_extra", n_ev, 0);
    model_last_rd = 1'b1;

    // Top-of-memory address, with address zero as a wrap-corruption witness
    run_txn(1'b1, 1'b0, 20'h00000, 16'hA5A5, 20'h0);
    run_txn(1'b1, 1'b0, 20'hFFFFF, 16'h1234, 20'h0);
    run_txn(1'b0, 1'b1, 20'h0, 16'h0, 20'hFFFFF);
    run_txn(1'b0, 1'b1, 20'h0, 16'h0, 20'h00000);

    // Reset in the second write strobe cycle aborts with no ack
    abort_pre = '0;
    wr_addr = 20'h03333; wr_data = 16'h4444; wr_req = 1'b1;
    tick();
    tick();
    check("abort_in_wr", {31'h0, sram_we_n}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {29'h0, sram_we_n, sram_ce_n, busy}, 32'h6);
    check("abort_dq", {16'h0, sram_dq}, 32'h0000FFFF);
    check("abort_no_ack", {31'h0, wr_ack}, 32'h0);
    wr_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last_rd = 1'b1;
    n_ack = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (wr_ack) n_ack++;
      abort_pre = abort_pre | {15'h0, busy};
    end
    $display("abort: acks after reset=%0d busy_seen=%0b", n_ack, abort_pre[0]);
    check("abort_ack_after", n_ack, 0);
    check("abort_idle_after", {16'h0, abort_pre}, 32'h0);

    // Read request dropped right after its grant
    rd_addr = 20'h00010; rd_req = 1'b1;
    tick();
    check("drop_granted", {31'h0, sram_oe_n}, 32'h0);
    rd_req = 1'b0;
    n_oe = 1; n_val = 0; val_t = -1;
    for (int t = 2; t <= 12; t++) begin
      tick();
      if (!sram_oe_n) n_oe++;
      if (rd_valid) begin
        n_val++;
        val_t = t;
        check("drop_rd_data", {16'h0, rd_data}, {16'h0, ref_mem[20'h00010]});
      end
    end
    $display("drop: valid@%0d valids=%0d oe_cycles=%0d", val_t, n_val, n_oe);
    check("drop_valid_count", n_val, 1);
    check("drop_valid_latency", val_t, AC + 1);
    check("drop_oe_cycles", n_oe, AC);
    check("drop_idle", {31'h0, busy}, 32'h0);
    model_last_rd = 1'b1;

    // Random mix of single and simultaneous requests
    for (int it = 0; it < 40; it++) begin
      int          mode;
      logic [19:0] wa, ra;
      logic [15:0] wd;
      mode = int'($urandom_range(0, 2));
      wa   = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, pool.size() - 1)] : 20'($urandom);
      wd   = 16'($urandom_range(0, 32'hFFFE));
      ra   = pool[$urandom_range(0, pool.size() - 1)];
      run_txn(mode != 1, mode != 0, wa, wd, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
